// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_decoder
//  Purpose  : Pops bytes from the UART RX FIFO and hunts for a start-of-frame
//             byte. It then parses [SOF][LEN][PAYLOAD x LEN][CHK] and streams
//             the payload bytes out on a valid/ready interface. Each frame
//             ends with one status pulse: good, length error, checksum error
//             or inter-byte timeout.
//  Ports    : i_clk, i_rst_n      clock, asynchronous active-low reset
//             i_rx_data/i_rx_rdy  FIFO read data (valid the cycle after a pop)
//                                 and FIFO not-empty flag
//             o_rx_req            one-cycle FIFO pop request
//             o_data/o_valid/o_last/i_ready  payload stream
//             o_frame_ok/o_frame_err/o_err_code  per-frame status pulse
//                                 (err code: 01 LEN, 10 CHK, 11 TIMEOUT)
//             o_busy              high whenever a frame is being parsed
//  Revision : 1.0  initial release
// ============================================================================
module uart_frame_decoder #(
    parameter int           MaxLen        = 64,
    parameter logic [7:0]   SofByte       = 8'hA5,
    parameter int           TimeoutCycles = 50_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_rdy,
    output logic        o_rx_req,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_last,
    input  logic        i_ready,
    output logic        o_frame_ok,
    output logic        o_frame_err,
    output logic [1:0]  o_err_code,
    output logic        o_busy
);

    localparam int             TW        = $clog2(TimeoutCycles);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TimeoutCycles - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MaxLen);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHK     = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           cap_q;              // FIFO data is valid this cycle
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     sum_q, sum_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic           ok_q, ok_d;
    logic           err_q, err_d;
    logic [1:0]     code_q, code_d;

    logic           w_req;
    logic           w_expire;
    logic [7:0]     w_sum_next;

    // Every state consumes bytes. A request is not allowed while the previous
    // pop is still being captured, nor while the output register is stalled.
    // This keeps an outstanding payload byte from being overwritten.
    assign w_req      = i_rst_n & i_rx_rdy & ~cap_q & (~valid_q | i_ready);
    assign w_sum_next = sum_q + i_rx_data;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        data_d   = data_q;
        valid_d  = valid_q & ~i_ready;
        last_d   = last_q & valid_q & ~i_ready;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = ERR_NONE;
        tmo_d    = tmo_q;
        w_expire = 1'b0;

        // Inter-byte timer: idle in IDLE, held at zero on a capture or while
        // downstream owns a pending byte (a stall is not the sender's fault).
        if (cap_q || valid_q || state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d    = '0;
            w_expire = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        // A capture takes priority over a timeout expiring in the same cycle.
        if (cap_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_rx_data == SofByte) begin
                        state_d = S_LEN;
                        sum_d   = 8'h00;
                    end
                end
                S_LEN: begin
                    if (i_rx_data == 8'h00 || i_rx_data > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = i_rx_data;
                        sum_d   = i_rx_data;
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    data_d  = i_rx_data;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == 8'd1);
                    sum_d   = w_sum_next;
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (w_sum_next == 8'h00) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (w_expire) begin
            err_d   = 1'b1;
            code_d  = ERR_TMO;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cap_q   <= 1'b0;
            cnt_q   <= 8'h00;
            sum_q   <= 8'h00;
            tmo_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cap_q   <= w_req;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign o_rx_req    = w_req;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_frame_ok  = ok_q;
    assign o_frame_err = err_q;
    assign o_err_code  = code_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
